// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl: WIDTH-bit adder built from one 4-bit ripple slice, one nibble per clock, LSB first.
// Optional feature: define SUB_EN to add the sub port (a - b computed as a + ~b + 1).
module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SUB_EN
    input  logic             sub,
`endif
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             busy
);
    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIB - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
    logic             carry_q, carry_d, cout_q, cout_d, valid_q, valid_d;
    logic [WIDTH-1:0] b_in;
    logic             c_in;
    logic [3:0]       an, bn, s;
    logic [4:0]       cv;

`ifdef SUB_EN
    // Operand conditioning at accept: subtraction feeds ~b with a forced carry-in of 1
    always_comb begin
        b_in = sub ? ~b : b;
        c_in = sub | cin;
    end
`else
    // Plain addition: operands pass straight through
    always_comb begin
        b_in = b;
        c_in = cin;
    end
`endif

    // 4-bit ripple slice working on the nibble selected by idx
    always_comb begin
        an    = a_q[4*idx_q +: 4];
        bn    = b_q[4*idx_q +: 4];
        s     = '0;
        cv    = '0;
        cv[0] = carry_q;
        for (int i = 0; i < 4; i++) begin
            s[i]    = an[i] ^ bn[i] ^ cv[i];
            cv[i+1] = (an[i] & bn[i]) | (cv[i] & (an[i] ^ bn[i]));
        end
    end

    // Sequencer: accept in IDLE, one nibble per RUN cycle, hold result in DONE until taken
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        result_d = result_q;
        cout_d   = cout_q;
        valid_d  = valid_q;
        case (state_q)
            IDLE: if (start_valid) begin
                a_d     = a;
                b_d     = b_in;
                carry_d = c_in;
                idx_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                result_d[4*idx_q +: 4] = s;
                carry_d = cv[4];
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    cout_d  = cv[4];
                    valid_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: if (result_ready) begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            valid_q  <= valid_d;
        end
    end

    assign start_ready  = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign result       = result_q;
    assign cout         = cout_q;
    assign result_valid = valid_q;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb_nibble_serial_adder_ctrl: directed bench with a per-cycle behavioural model of nibble_serial_adder_ctrl.
module tb_nibble_serial_adder_ctrl;
    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start_valid = 1'b0, result_ready = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         cin = 1'b0, sub = 1'b0;
    logic         start_ready, cout, result_valid, busy;
    logic [W-1:0] result;
    int           n_checks = 0, n_fail = 0, cyc = 0;

    nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
        .a(a), .b(b), .cin(cin),
`ifdef SUB_EN
        .sub(sub),
`endif
        .result(result), .cout(cout), .result_valid(result_valid),
        .result_ready(result_ready), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    logic sub_eff;
`ifdef SUB_EN
    assign sub_eff = sub;
`else
    assign sub_eff = 1'b0;
`endif

    // Model: cycles of computation left, result pending flag, expected and last {cout,result}
    int        m_left = 0;
    bit        m_valid = 0;
    logic [W:0] m_exp = '0, m_last = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_result", result, 0);
            chk("rst_cout", cout, 0);
            chk("rst_valid", result_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_start_ready", start_ready, 1);
            m_left = 0; m_valid = 0; m_exp = '0; m_last = '0;
        end else begin
            chk("busy", busy, (m_left > 0) || m_valid);
            chk("start_ready", start_ready, !((m_left > 0) || m_valid));
            chk("result_valid", result_valid, m_valid);
            if (m_valid) chk("sum", {cout, result}, m_exp);
            else if (m_left == 0) chk("idle_hold", {cout, result}, m_last);
            if (m_valid) begin
                if (result_ready) begin m_valid = 0; m_last = m_exp; end
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) m_valid = 1;
            end else if (start_valid) begin
                m_exp  = {1'b0, a} + {1'b0, sub_eff ? ~b : b} + (W+1)'(sub_eff ? 1'b1 : cin);
                m_left = NIB;
            end
        end
    end

    // All tasks start and end at #1 after a rising edge
    task automatic issue(input logic [W-1:0] ta, tb2, input logic tc, ts, input bit keep);
        int n = 0;
        a = ta; b = tb2; cin = tc; sub = ts; start_valid = 1'b1;
        while (!start_ready && n < 20) begin @(posedge clk); #1; n++; end
        chk("accept_timeout", n < 20, 1);
        @(posedge clk); #1;
        if (!keep) start_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!result_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        chk("valid_timeout", lat < 20, 1);
    endtask

    task automatic op(input logic [W-1:0] ta, tb2, input logic tc, ts,
                      input logic [W-1:0] er, input logic ec, input string nm);
        int lat;
        issue(ta, tb2, tc, ts, 0);
        wait_valid(lat);
        chk({nm, "_latency"}, lat, NIB);
        chk({nm, "_result"}, result, er);
        chk({nm, "_cout"}, cout, ec);
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        chk({nm, "_back_idle"}, start_ready, 1);
    endtask

    typedef struct { logic [W-1:0] ta, tb2; logic tc; logic [W-1:0] er; logic ec; } vec_t;
    vec_t b2b[5];
    int   lat, last_acc, acc;
    logic [W-1:0] hold_r;
    logic         hold_c;

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_start_ready", start_ready, 1);
        chk("reset_result", result, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        op(16'h1234, 16'h4321, 0, 0, 16'h5555, 0, "basic");
        op(16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, "ripple_b1");
        op(16'hFFFF, 16'h0000, 1, 0, 16'h0000, 1, "ripple_cin");
        op(16'h0F0F, 16'h00F1, 0, 0, 16'h1000, 0, "ripple_mid");

        // Backpressure with a start attempt while DONE
        issue(16'h00FF, 16'h0101, 0, 0, 0);
        wait_valid(lat);
        hold_r = result; hold_c = cout;
        chk("bp_result", hold_r, 16'h0200);
        for (int i = 0; i < 5; i++) begin
            start_valid = (i == 2);
            a = 16'h7777; b = 16'h1111;
            @(posedge clk); #1;
            chk("bp_valid_held", result_valid, 1);
            chk("bp_result_stable", {hold_c, hold_r}, {cout, result});
            chk("bp_start_ready", start_ready, 0);
        end
        start_valid = 1'b0;
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        chk("bp_release_idle", busy, 0);
        chk("bp_release_valid", result_valid, 0);

        // Reset during the second RUN cycle
        issue(16'hAAAA, 16'h5555, 0, 0, 0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_result", result, 0);
        chk("midrst_cout", cout, 0);
        chk("midrst_valid", result_valid, 0);
        chk("midrst_busy", busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("midrst_no_valid", result_valid, 0);
        end
        op(16'h0001, 16'h0002, 0, 0, 16'h0003, 0, "post_reset");

        // Back-to-back with start_valid and result_ready tied high
        b2b[0] = '{16'h1111, 16'h2222, 0, 16'h3333, 0};
        b2b[1] = '{16'h8000, 16'h8000, 0, 16'h0000, 1};
        b2b[2] = '{16'hABCD, 16'h1234, 1, 16'hBE02, 0};
        b2b[3] = '{16'hFFFF, 16'hFFFF, 1, 16'hFFFF, 1};
        b2b[4] = '{16'h0F0F, 16'h00F1, 0, 16'h1000, 0};
        result_ready = 1'b1;
        last_acc = 0;
        for (int i = 0; i < 5; i++) begin
            issue(b2b[i].ta, b2b[i].tb2, b2b[i].tc, 0, 1);
            acc = cyc;
            if (i > 0) chk("b2b_spacing", acc - last_acc, NIB + 2);
            last_acc = acc;
            wait_valid(lat);
            chk("b2b_result", result, b2b[i].er);
            chk("b2b_cout", cout, b2b[i].ec);
        end
        start_valid = 1'b0;
        @(posedge clk); #1;
        result_ready = 1'b0;

`ifdef SUB_EN
        op(16'h0005, 16'h0007, 0, 1, 16'hFFFE, 0, "sub_borrow");
        op(16'h0007, 16'h0005, 0, 1, 16'h0002, 1, "sub_noborrow");
        op(16'h0007, 16'h0005, 1, 1, 16'h0002, 1, "sub_cin_ignored");
        op(16'h0007, 16'h0005, 1, 0, 16'h000D, 0, "sub0_add");
`endif

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/nibble_serial_adder_ctrl.md
# nibble_serial_adder_ctrl

Sequencer that adds two WIDTH-bit operands by time-multiplexing one internal 4-bit ripple full-adder slice, one nibble per clock, LSB nibble first. The carry is held in a register between nibbles. The block sits between a requester (start handshake) and a consumer (result handshake). It is the multi-cycle controller around the team's 4-bit adder datapath, trading area for latency on wide operands.

## Interface
- WIDTH, 16, operand/result width in bits; multiple of 4, minimum 8
- NIB (localparam), WIDTH/4, nibble count per operation

- clk  input  1  rising-edge clock, the only clock
- rst_n  input  1  asynchronous active-low reset
- start_valid  input  1  requester has an operation
- start_ready  output  1  block accepts an operation; equals (state==IDLE)
- a  input  WIDTH  operand A, sampled at accept
- b  input  WIDTH  operand B, sampled at accept
- cin  input  1  carry-in to nibble 0, sampled at accept
- sub  input  1  subtract select, sampled at accept (present only with SUB_EN)
- result  output  WIDTH  sum, registered
- cout  output  1  carry out of MSB nibble, registered
- result_valid  output  1  result/cout valid
- result_ready  input  1  consumer takes result
- busy  output  1  state != IDLE

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - on start_valid && start_ready, latch a→a_q, b→b_q, cin→carry_q; clear idx to 0; go to RUN.
- RUN, each cycle:
  - {c, s} = a_q[4*idx+:4] + b_q[4*idx+:4] + carry_q via the 4-bit ripple slice (per-bit full adders);
  - result[4*idx+:4] <= s; carry_q <= c; idx <= idx+1.
  - On idx==NIB-1: cout <= c, result_valid <= 1, go to DONE.
- DONE:
  - result_valid held high; result and cout held stable.
  - On result_ready: result_valid <= 0, go to IDLE.
- start_ready is low in RUN and DONE; start_valid in those states is ignored with no queuing.
- Arithmetic: result = (a + b + cin) mod 2^WIDTH; cout = bit WIDTH of the full-width sum.
- result keeps its last value in IDLE. Nibbles not yet written in RUN hold stale values; result is only meaningful while result_valid is high.
- Reset (asynchronous, any state, including mid-RUN):
  - state=IDLE, idx=0, carry_q=0, a_q=b_q=0;
  - result=0, cout=0, result_valid=0, busy=0;
  - start_ready=1 from IDLE, but inputs are ignored while rst_n is low.
  - The in-flight operation is discarded and no result_valid is produced.

## Timing
- Accept at edge E0 (state IDLE→RUN).
- Nibbles k=0..NIB-1 are computed at edges E1..E_NIB.
- result_valid rises after E_NIB, giving a latency of NIB cycles from accept (4 for WIDTH=16).
- If result_ready is high in the first DONE cycle, the block returns to IDLE at E_NIB+1. The next accept is possible at E_NIB+2, for a minimum issue interval of NIB+2 cycles.
- result_ready is ignored unless result_valid is high.
- There is no combinational path from start_valid or result_ready to any output. start_ready and busy decode only from the state register.

## Configuration
- SUB_EN defined:
  - adds the sub port.
  - At accept with sub=1: b_q <= ~b, carry_q <= 1 (cin ignored), so result = (a - b) mod 2^WIDTH. cout=1 means no borrow (a>=b); cout=0 means borrow.
  - With sub=0 at accept, behaviour is identical to plain addition.
- SUB_EN undefined: no sub port; the block always adds; no inverter logic is synthesized.

## Test plan
- WIDTH=16, a=0x1234, b=0x4321, cin=0 → result=0x5555, cout=0, result_valid exactly 4 cycles after accept, busy high for 5 cycles.
- Full ripple across all nibbles:
  - a=0xFFFF, b=0x0001, cin=0 → result=0x0000, cout=1.
  - a=0xFFFF, b=0x0000, cin=1 → result=0x0000, cout=1.
  - a=0x0F0F, b=0x00F1, cin=0 → result=0x1000, cout=0.
- Backpressure: result_ready held low 5 cycles in DONE → result_valid stays 1, result/cout stable, start_ready=0, a start_valid pulse during DONE is not accepted. Raising result_ready returns the block to IDLE on the next edge.
- Reset mid-operation: rst_n low during the second RUN cycle → result=0, cout=0, result_valid=0, busy=0 immediately, with no later result_valid. A subsequent operation a=0x0001, b=0x0002 yields result=0x0003.
- Back-to-back: start_valid and result_ready tied high with different operands each operation → accepts are spaced exactly NIB+2=6 cycles apart, and every result is correct (including a=0x8000, b=0x8000 → 0x0000, cout=1).
- SUB_EN build:
  - a=0x0005, b=0x0007, sub=1 → result=0xFFFE, cout=0.
  - a=0x0007, b=0x0005, sub=1 → result=0x0002, cout=1.
  - cin=1 with sub=1 has no effect on the result.
